bip_data_mem_arbiter: RTL and testbench

// - Shares the single-port, synchronous-read BIP data memory between two requesters:
//   the CPU datapath (port A) and the debug/UART dump unit (port B).
// - Issues at most one access per cycle and routes read data back to its owner.
// - CPU has fixed priority; a wait counter guarantees debug forward progress.
// - Sits between the CPU/debug unit and the data memory instance.

---
 rtl/bip_data_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bip_data_mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bip_data_mem_arbiter.sv
// bip_data_mem_arbiter: shares the single-port, synchronous-read BIP data
// memory between the CPU datapath (port A) and the debug/UART dump unit
// (port B). At most one access is issued per cycle, and read data is routed
// back to the port that issued the read.
// Optional build macro ARB_ROUND_ROBIN_EN:
//   defined   -> ties alternate between the two ports (1-bit last_gnt).
//   undefined -> CPU has fixed priority; a MAX_WAIT counter forces a debug
//                grant after a run of denied debug requests.
module bip_data_mem_arbiter #(
  parameter int NB_DATA    = 16,
  parameter int NB_OPERAND = 11,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [NB_OPERAND-1:0] i_cpu_addr,
  input  logic [NB_DATA-1:0]    i_cpu_wdata,
  output logic                  out_cpu_gnt,
  output logic [NB_DATA-1:0]    out_cpu_rdata,
  output logic                  out_cpu_rvalid,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [NB_OPERAND-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0]    i_dbg_wdata,
  output logic                  out_dbg_gnt,
  output logic [NB_DATA-1:0]    out_dbg_rdata,
  output logic                  out_dbg_rvalid,
  output logic                  out_mem_en,
  output logic                  out_mem_we,
  output logic [NB_OPERAND-1:0] out_mem_addr,
  output logic [NB_DATA-1:0]    out_mem_wdata,
  input  logic [NB_DATA-1:0]    i_mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  owner_e rd_owner_q;
  owner_e rd_owner_d;
  logic   cpu_gnt;
  logic   dbg_gnt;

`ifdef ARB_ROUND_ROBIN_EN
  // last_gnt: 1 = debug was granted last, 0 = CPU was granted last.
  logic last_gnt_q;
  logic last_gnt_d;

  // Arbitration: a sole requester wins; on a tie the port not granted last wins.
  // Grants are suppressed while reset is asserted so every output is quiet.
  always_comb begin
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    last_gnt_d = last_gnt_q;
    if (!i_reset) begin
      if (i_cpu_req && i_dbg_req) begin
        if (last_gnt_q) begin
          cpu_gnt = 1'b1;
        end else begin
          dbg_gnt = 1'b1;
        end
      end else if (i_cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (i_dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
    if (cpu_gnt) begin
      last_gnt_d = 1'b0;
    end else if (dbg_gnt) begin
      last_gnt_d = 1'b1;
    end
  end

  // Round-robin history register; resets to "debug last" so the CPU wins the first tie.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`else
  localparam int                 NB_WAIT    = 4;
  localparam logic [NB_WAIT-1:0] MAX_WAIT_C = NB_WAIT'(MAX_WAIT);

  logic [NB_WAIT-1:0] wait_cnt_q;
  logic [NB_WAIT-1:0] wait_cnt_d;

  // Arbitration: a starved debug request beats the CPU, otherwise the CPU has priority.
  // Grants are suppressed while reset is asserted so every output is quiet.
  always_comb begin
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    wait_cnt_d = wait_cnt_q;
    if (!i_reset) begin
      if (i_dbg_req && (wait_cnt_q == MAX_WAIT_C)) begin
        dbg_gnt = 1'b1;
      end else if (i_cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (i_dbg_req) begin
        dbg_gnt = 1'b1;
      end
    end
    if (dbg_gnt || !i_dbg_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Count of consecutive denied debug-request cycles.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`endif

  // Memory command mux: the granted port's command, all zeros when idle.
  always_comb begin
    out_mem_en    = 1'b0;
    out_mem_we    = 1'b0;
    out_mem_addr  = '0;
    out_mem_wdata = '0;
    if (cpu_gnt) begin
      out_mem_en    = 1'b1;
      out_mem_we    = i_cpu_we;
      out_mem_addr  = i_cpu_addr;
      out_mem_wdata = i_cpu_wdata;
    end else if (dbg_gnt) begin
      out_mem_en    = 1'b1;
      out_mem_we    = i_dbg_we;
      out_mem_addr  = i_dbg_addr;
      out_mem_wdata = i_dbg_wdata;
    end
  end

  // Read-owner next state: a granted read claims the next cycle's read data.
  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !i_cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dbg_gnt && !i_dbg_we) begin
      rd_owner_d = OWN_DBG;
    end
  end

  // Read-owner state register; reset drops any read in flight.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  // Output steering: grants straight from arbitration, read data only to its owner.
  always_comb begin
    out_cpu_gnt    = cpu_gnt;
    out_dbg_gnt    = dbg_gnt;
    out_cpu_rvalid = (rd_owner_q == OWN_CPU);
    out_dbg_rvalid = (rd_owner_q == OWN_DBG);
    out_cpu_rdata  = (rd_owner_q == OWN_CPU) ? i_mem_rdata : '0;
    out_dbg_rdata  = (rd_owner_q == OWN_DBG) ? i_mem_rdata : '0;
  end

endmodule

// File: tb/tb_bip_data_mem_arbiter.sv
// Scoreboard bench for bip_data_mem_arbiter: the stimulus pushes the expected
// grant and read-return records, and a negedge monitor pops and compares them.
module tb_bip_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [10:0] cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        out_cpu_gnt, out_cpu_rvalid, out_dbg_gnt, out_dbg_rvalid;
  logic [15:0] out_cpu_rdata, out_dbg_rdata;
  logic        mem_en, mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          who;
    bit          we;
    logic [10:0] addr;
    logic [15:0] wdata;
  } gnt_rec_t;

  typedef struct {
    int          who;
    logic [15:0] data;
  } rd_rec_t;

  gnt_rec_t exp_g[$];
  rd_rec_t  exp_r[$];

  always #5 clk = ~clk;

  bip_data_mem_arbiter #(.NB_DATA(16), .NB_OPERAND(11), .MAX_WAIT(4)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .out_cpu_gnt(out_cpu_gnt), .out_cpu_rdata(out_cpu_rdata), .out_cpu_rvalid(out_cpu_rvalid),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .out_dbg_gnt(out_dbg_gnt), .out_dbg_rdata(out_dbg_rdata), .out_dbg_rvalid(out_dbg_rvalid),
    .out_mem_en(mem_en), .out_mem_we(mem_we), .out_mem_addr(mem_addr),
    .out_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Data memory model: single port, registered read.
  logic [15:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one compare set per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_g.size() > 0) begin
        gnt_rec_t g;
        g = exp_g.pop_front();
        chk("cpu_gnt",   32'(out_cpu_gnt), 32'(g.who == 1));
        chk("dbg_gnt",   32'(out_dbg_gnt), 32'(g.who == 2));
        chk("mem_en",    32'(mem_en),      32'(g.who != 0));
        chk("mem_we",    32'(mem_we),      32'((g.who != 0) && g.we));
        chk("mem_addr",  32'(mem_addr),    (g.who != 0) ? 32'(g.addr) : 32'h0);
        chk("mem_wdata", 32'(mem_wdata),   (g.who != 0) ? 32'(g.wdata) : 32'h0);
        $display("cycle t=%0t who=%0d cpu_gnt=%0b dbg_gnt=%0b en=%0b we=%0b addr=%03h",
                 $time, g.who, out_cpu_gnt, out_dbg_gnt, mem_en, mem_we, mem_addr);
      end else if (out_cpu_gnt || out_dbg_gnt) begin
        chk("unexpected_gnt", 32'({out_cpu_gnt, out_dbg_gnt}), 32'h0);
      end
      if (out_cpu_rvalid || out_dbg_rvalid) begin
        if (exp_r.size() == 0) begin
          chk("unexpected_rvalid", 32'({out_cpu_rvalid, out_dbg_rvalid}), 32'h0);
        end else begin
          rd_rec_t r;
          r = exp_r.pop_front();
          chk("cpu_rvalid", 32'(out_cpu_rvalid), 32'(r.who == 1));
          chk("dbg_rvalid", 32'(out_dbg_rvalid), 32'(r.who == 2));
          chk("cpu_rdata",  32'(out_cpu_rdata),  (r.who == 1) ? 32'(r.data) : 32'h0);
          chk("dbg_rdata",  32'(out_dbg_rdata),  (r.who == 2) ? 32'(r.data) : 32'h0);
          $display("read t=%0t owner=%0d data=%04h", $time, r.who, r.data);
        end
      end
    end
  end

  // Drive one cycle of requests and queue what the arbiter must do with them.
  // who: 0 = no grant, 1 = CPU, 2 = debug; rdata is the word a granted read returns.
  task automatic step(input bit creq, input bit cwe, input logic [10:0] caddr,
                      input logic [15:0] cwd, input bit dreq, input bit dwe,
                      input logic [10:0] daddr, input logic [15:0] dwd,
                      input int who, input logic [15:0] rdata);
    gnt_rec_t g;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
    g.who = who; g.we = 1'b0; g.addr = '0; g.wdata = '0;
    if (who == 1) begin
      g.we = cwe; g.addr = caddr; g.wdata = cwd;
    end else if (who == 2) begin
      g.we = dwe; g.addr = daddr; g.wdata = dwd;
    end
    exp_g.push_back(g);
    if (who != 0 && !g.we) exp_r.push_back('{who, rdata});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 11'h0, 16'h0, 0, 0, 11'h0, 16'h0, 0, 16'h0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_cpu_gnt"},    32'(out_cpu_gnt),    32'h0);
    chk({tag, "_dbg_gnt"},    32'(out_dbg_gnt),    32'h0);
    chk({tag, "_cpu_rvalid"}, 32'(out_cpu_rvalid), 32'h0);
    chk({tag, "_dbg_rvalid"}, 32'(out_dbg_rvalid), 32'h0);
    chk({tag, "_cpu_rdata"},  32'(out_cpu_rdata),  32'h0);
    chk({tag, "_mem_en"},     32'(mem_en),         32'h0);
    chk({tag, "_mem_we"},     32'(mem_we),         32'h0);
    chk({tag, "_mem_addr"},   32'(mem_addr),       32'h0);
    chk({tag, "_mem_wdata"},  32'(mem_wdata),      32'h0);
  endtask

  string seq;
  int    who;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
    mem[11'h010] = 16'h1234;
    mem[11'h005] = 16'hAAAA;
    mem_rdata = 16'h0;

    // Reset with both ports requesting: everything must stay quiet.
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h123; cpu_wdata = 16'h5555;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'h456; dbg_wdata = 16'h6666;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b0;
    idle();

    // Reset during a read: the granted CPU read never returns.
    step(1, 0, 11'h005, 16'h0, 0, 0, 11'h0, 16'h0, 1, 16'hAAAA);
    void'(exp_r.pop_back());
    cpu_req = 1'b0; dbg_req = 1'b0;
    rst = 1'b1;
    #2;
    check_quiet("rst_rd");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    idle();

    // CPU read only, then a CPU write and read-back.
    step(1, 0, 11'h010, 16'h0, 0, 0, 11'h0, 16'h0, 1, 16'h1234);
    idle();
    step(1, 1, 11'h020, 16'h5A5A, 0, 0, 11'h0, 16'h0, 1, 16'h0);
    step(1, 0, 11'h020, 16'h0, 0, 0, 11'h0, 16'h0, 1, 16'h5A5A);
    idle();

    // Debug write to the top address, then debug read-back.
    step(0, 0, 11'h0, 16'h0, 1, 1, 11'h7FF, 16'hBEEF, 2, 16'h0);
    step(0, 0, 11'h0, 16'h0, 1, 0, 11'h7FF, 16'h0, 2, 16'hBEEF);
    idle();

    // Back-to-back reads: CPU then debug.
    step(1, 0, 11'h010, 16'h0, 0, 0, 11'h0, 16'h0, 1, 16'h1234);
    step(0, 0, 11'h0, 16'h0, 1, 0, 11'h7FF, 16'h0, 2, 16'hBEEF);
    idle();

    // Contention: 3 tie cycles, 1 cycle with debug dropped, 10 tie cycles, 3 CPU-only.
`ifdef ARB_ROUND_ROBIN_EN
    seq = "CDCCDCDCDCDCDCCCC";
`else
    seq = "CCCCCCCCDCCCCDCCC";
`endif
    for (int i = 0; i < 17; i++) begin
      who = (seq[i] == "C") ? 1 : 2;
      step(1, 0, 11'h010, 16'h0, (i != 3 && i < 14), 0, 11'h7FF, 16'h0,
           who, (who == 1) ? 16'h1234 : 16'hBEEF);
    end
    idle();
    idle();

    chk("gnt_queue_empty", 32'(exp_g.size()), 32'h0);
    chk("rd_queue_empty",  32'(exp_r.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
